ss_read_burst: RTL and testbench

//   Parametrised RAM burst reader: the successor to the single-pass index reader.
//   On a start edge it walks RAM addresses from a start index to an end index,

---
 rtl/ss_read_burst_if.sv | 31 +++
 rtl/ss_read_burst.sv | 201 ++++++++++++++++++++
 tb/tb_ss_read_burst.sv | 403 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ss_read_burst_if.sv
// Bus bundle for ss_read_burst: RAM read port plus the valid/ready output stream.
// The master side is the burst reader; the slave side is the RAM and downstream sink.
interface ss_read_burst_if #(
    parameter int SIZE_ADDR = 6,
    parameter int SIZE_DATA = 8
);
    logic [SIZE_ADDR-1:0] o_addr_ram;
    logic                 o_rd_en_ram;
    logic [SIZE_DATA-1:0] i_data_ram;
    logic [SIZE_DATA-1:0] o_data;
    logic                 o_data_valid;
    logic                 i_data_ready;

    modport master (
        output o_addr_ram,
        output o_rd_en_ram,
        input  i_data_ram,
        output o_data,
        output o_data_valid,
        input  i_data_ready
    );

    modport slave (
        input  o_addr_ram,
        input  o_rd_en_ram,
        output i_data_ram,
        input  o_data,
        input  o_data_valid,
        output i_data_ready
    );
endinterface

// File: rtl/ss_read_burst.sv
// ss_read_burst: on a start edge, reads RAM from si to ei (inclusive, wrapping) and streams
// the words out through a 2-entry FIFO. Define SS_READ_BURST_STRIDE_EN to add the i_stride port.
module ss_read_burst #(
    parameter int SIZE_ADDR   = 6,
    parameter int SIZE_DATA   = 8,
    parameter int SIZE_STRIDE = 3
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_start,
    input  logic                   i_abort,
    input  logic [SIZE_ADDR-1:0]   i_si_ram,
    input  logic [SIZE_ADDR-1:0]   i_ei_ram,
`ifdef SS_READ_BURST_STRIDE_EN
    input  logic [SIZE_STRIDE-1:0] i_stride,
`endif
    ss_read_burst_if.master        bus,
    output logic                   o_busy,
    output logic [SIZE_ADDR:0]     o_count,
    output logic                   o_done
);
    // Offset must hold dist + step without wrapping, whichever of the two is wider.
    localparam int STEP_W = (SIZE_STRIDE > SIZE_ADDR) ? SIZE_STRIDE : SIZE_ADDR;
    localparam int OFF_W  = STEP_W + 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_READ,
        ST_DRAIN,
        ST_DONE
    } state_e;

    state_e               state_q, state_d;
    logic                 start_prev_q, start_prev_d;
    logic [SIZE_ADDR-1:0] addr_q, addr_d;
    logic [SIZE_ADDR-1:0] dist_q, dist_d;
    logic [OFF_W-1:0]     offset_q, offset_d;
    logic                 in_flight_q, in_flight_d;
    logic [1:0]           occ_q, occ_d;
    logic                 rd_ptr_q, rd_ptr_d;
    logic                 wr_ptr_q, wr_ptr_d;
    logic [SIZE_DATA-1:0] fifo_mem_q [2];
    logic [SIZE_DATA-1:0] fifo_mem_d [2];
    logic [SIZE_ADDR:0]   count_q, count_d;
    logic [STEP_W-1:0]    step;

    logic                 start_edge;
    logic                 burst_active;
    logic                 abort_hit;
    logic                 pop;
    logic                 push;
    logic                 issue;
    logic                 last_issue;
    logic                 data_valid;
    logic [2:0]           slots_used;
    logic [1:0]           occ_after;
    logic [OFF_W-1:0]     offset_sum;

`ifdef SS_READ_BURST_STRIDE_EN
    logic [STEP_W-1:0]    step_q, step_d;
    assign step = step_q;
`else
    assign step = STEP_W'(1);
`endif

    // NOTE: combinational blocks use blocking '=' so later lines see earlier results;
    // clocked blocks use '<=' so every flop samples pre-edge values.
    always_comb begin
        start_edge   = i_start & ~start_prev_q;
        burst_active = (state_q == ST_READ) || (state_q == ST_DRAIN);
        abort_hit    = burst_active & i_abort;
        data_valid   = (occ_q != 2'd0);
        pop          = data_valid & bus.i_data_ready;
        push         = in_flight_q & ~abort_hit;
        slots_used   = 3'(occ_q) + 3'(in_flight_q) - 3'(pop);
        issue        = (state_q == ST_READ) & ~i_abort & (slots_used < 3'd2);
        offset_sum   = offset_q + OFF_W'(step);
        last_issue   = offset_sum > OFF_W'(dist_q);
        occ_after    = occ_q + 2'(push) - 2'(pop);
    end

    // NOTE: every variable gets a default before any branch, otherwise a path that
    // skips an assignment would infer a latch.
    always_comb begin
        state_d      = state_q;
        start_prev_d = i_start;
        addr_d       = addr_q;
        dist_d       = dist_q;
        offset_d     = offset_q;
        in_flight_d  = issue;
        occ_d        = occ_after;
        rd_ptr_d     = rd_ptr_q ^ pop;
        wr_ptr_d     = wr_ptr_q ^ push;
        count_d      = count_q + (SIZE_ADDR+1)'(pop);
`ifdef SS_READ_BURST_STRIDE_EN
        step_d       = step_q;
`endif
        for (int i = 0; i < 2; i++) begin
            fifo_mem_d[i] = fifo_mem_q[i];
        end
        if (push) begin
            fifo_mem_d[wr_ptr_q] = bus.i_data_ram;
        end

        unique case (state_q)
            ST_IDLE: begin
                if (start_edge && !i_abort) begin
                    state_d  = ST_READ;
                    addr_d   = i_si_ram;
                    dist_d   = i_ei_ram - i_si_ram;
                    offset_d = '0;
                    count_d  = '0;
`ifdef SS_READ_BURST_STRIDE_EN
                    step_d   = (i_stride == '0) ? STEP_W'(1) : STEP_W'(i_stride);
`endif
                end
            end
            ST_READ: begin
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (issue) begin
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end else begin
                        addr_d   = addr_q + SIZE_ADDR'(step);
                        offset_d = offset_sum;
                    end
                end
            end
            ST_DRAIN: begin
                // Leave as soon as the final word is leaving, so done follows it directly.
                if (i_abort) begin
                    state_d = ST_IDLE;
                end else if (occ_after == 2'd0 && !in_flight_q) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (abort_hit) begin
            occ_d    = '0;
            rd_ptr_d = 1'b0;
            wr_ptr_d = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q      <= ST_IDLE;
            start_prev_q <= 1'b0;
            addr_q       <= '0;
            dist_q       <= '0;
            offset_q     <= '0;
            in_flight_q  <= 1'b0;
            occ_q        <= '0;
            rd_ptr_q     <= 1'b0;
            wr_ptr_q     <= 1'b0;
            count_q      <= '0;
`ifdef SS_READ_BURST_STRIDE_EN
            step_q       <= STEP_W'(1);
`endif
        end else begin
            state_q      <= state_d;
            start_prev_q <= start_prev_d;
            addr_q       <= addr_d;
            dist_q       <= dist_d;
            offset_q     <= offset_d;
            in_flight_q  <= in_flight_d;
            occ_q        <= occ_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
`ifdef SS_READ_BURST_STRIDE_EN
            step_q       <= step_d;
`endif
        end
    end

    // NOTE: FIFO storage is deliberately not reset; occupancy gates every read of it
    // and o_data is forced to zero while empty.
    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 2; i++) begin
            fifo_mem_q[i] <= fifo_mem_d[i];
        end
    end

    assign bus.o_addr_ram   = addr_q;
    assign bus.o_rd_en_ram  = issue;
    assign bus.o_data_valid = data_valid;
    assign bus.o_data       = data_valid ? fifo_mem_q[rd_ptr_q] : '0;

    assign o_busy  = (state_q != ST_IDLE);
    assign o_count = count_q;
    assign o_done  = (state_q == ST_DONE);
endmodule

// File: tb/tb_ss_read_burst.sv
// Self-checking bench for ss_read_burst: randomized bursts checked against a list-based model
// of the address walk. Define SS_READ_BURST_STRIDE_EN to also exercise the stride port.
module tb_ss_read_burst;
    localparam int SIZE_ADDR   = 6;
    localparam int SIZE_DATA   = 8;
    localparam int SIZE_STRIDE = 3;
    localparam int DEPTH       = 1 << SIZE_ADDR;

    logic                 i_clk = 1'b0;
    logic                 i_rst;
    logic                 i_start;
    logic                 i_abort;
    logic [SIZE_ADDR-1:0] i_si_ram;
    logic [SIZE_ADDR-1:0] i_ei_ram;
`ifdef SS_READ_BURST_STRIDE_EN
    logic [SIZE_STRIDE-1:0] i_stride;
`endif
    logic                 o_busy;
    logic [SIZE_ADDR:0]   o_count;
    logic                 o_done;

    ss_read_burst_if #(.SIZE_ADDR(SIZE_ADDR), .SIZE_DATA(SIZE_DATA)) bus ();

    ss_read_burst #(
        .SIZE_ADDR  (SIZE_ADDR),
        .SIZE_DATA  (SIZE_DATA),
        .SIZE_STRIDE(SIZE_STRIDE)
    ) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_start (i_start),
        .i_abort (i_abort),
        .i_si_ram(i_si_ram),
        .i_ei_ram(i_ei_ram),
`ifdef SS_READ_BURST_STRIDE_EN
        .i_stride(i_stride),
`endif
        .bus     (bus),
        .o_busy  (o_busy),
        .o_count (o_count),
        .o_done  (o_done)
    );

    always #5 i_clk = ~i_clk;

    logic [SIZE_DATA-1:0] ram [DEPTH];

    // RAM: one-cycle read latency; junk on the bus when not reading.
    always @(posedge i_clk) begin
        if (bus.o_rd_en_ram) bus.i_data_ram <= ram[bus.o_addr_ram];
        else                 bus.i_data_ram <= SIZE_DATA'($urandom);
    end

    int tests_run    = 0;
    int tests_failed = 0;

    int                   cyc = 0;
    bit                   mon_en = 1'b0;
    int                   iss_q [$];
    logic [SIZE_DATA-1:0] got_q [$];
    int                   first_valid_cyc = -1;
    int                   last_xfer_cyc = -1;
    int                   done_cyc = -1;
    int                   done_cnt = 0;
    bit                   prev_stall = 1'b0;
    logic [SIZE_DATA-1:0] prev_data;

    // Monitor on the falling edge: records issued addresses, transfers and done pulses.
    always @(negedge i_clk) begin
        cyc++;
        if (mon_en) begin
            if (bus.o_rd_en_ram) iss_q.push_back(int'(bus.o_addr_ram));
            if (bus.o_data_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (bus.o_data_valid && bus.i_data_ready) begin
                got_q.push_back(bus.o_data);
                last_xfer_cyc = cyc;
            end
            if (o_done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (prev_stall) begin
                tests_run++;
                if (!bus.o_data_valid || bus.o_data !== prev_data) begin
                    tests_failed++;
                    $display("FAIL stall_hold @%0d: valid=%0b data=%0h, required valid=1 data=%0h",
                             cyc, bus.o_data_valid, bus.o_data, prev_data);
                end
            end
            if (!bus.o_data_valid) begin
                tests_run++;
                if (bus.o_data !== '0) begin
                    tests_failed++;
                    $display("FAIL idle_data_zero @%0d: data=%0h, required 0", cyc, bus.o_data);
                end
            end
            prev_stall = bus.o_data_valid && !bus.i_data_ready && !i_abort && !i_rst;
            prev_data  = bus.o_data;
        end
    end

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic clear_mon();
        iss_q.delete();
        got_q.delete();
        first_valid_cyc = -1;
        last_xfer_cyc   = -1;
        done_cyc        = -1;
        done_cnt        = 0;
    endtask

    task automatic apply_reset();
        i_rst            = 1'b1;
        i_start          = 1'b0;
        i_abort          = 1'b0;
        bus.i_data_ready = 1'b1;
        tick();
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    task automatic set_burst(input int si, input int ei, input int s);
        i_si_ram = SIZE_ADDR'(si);
        i_ei_ram = SIZE_ADDR'(ei);
`ifdef SS_READ_BURST_STRIDE_EN
        i_stride = SIZE_STRIDE'(s);
`else
        if (s != 1) $display("note: stride %0d ignored without stride support", s);
`endif
    endtask

    // mode 0: ready held high, 1: ready toggles every cycle, 2: random ready.
    // poke: drop and re-raise i_start mid-burst; that edge must be ignored.
    task automatic run_burst(input int si, input int ei, input int s, input int mode,
                             input bit poke, input string name);
        int  st, n, budget, start_cyc, exp_a;
        bit  bad;
        st = (s == 0) ? 1 : s;
        n  = (((ei - si) % DEPTH + DEPTH) % DEPTH) / st + 1;

        clear_mon();
        set_burst(si, ei, s);
        i_start          = 1'b1;
        bus.i_data_ready = (mode == 1) ? 1'b0 : 1'b1;
        start_cyc        = cyc + 1;
        budget           = 0;
        while (done_cnt == 0 && budget < 700) begin
            tick();
            budget++;
            case (mode)
                0:       bus.i_data_ready = 1'b1;
                1:       bus.i_data_ready = ~bus.i_data_ready;
                default: bus.i_data_ready = 1'($urandom_range(0, 1));
            endcase
            if (poke && budget == 3) i_start = 1'b0;
            if (poke && budget == 4) i_start = 1'b1;
        end

        tests_run++;
        if (done_cnt == 0) begin
            tests_failed++;
            $display("FAIL %s timeout: no o_done within %0d cycles", name, budget);
            apply_reset();
            return;
        end

        // i_start stays high: the held level must not start another burst.
        bus.i_data_ready = 1'b1;
        tick();
        tick();
        @(negedge i_clk);

        tests_run++;
        if (iss_q.size() != n) begin
            tests_failed++;
            $display("FAIL %s addr_count: issued %0d reads, required %0d", name, iss_q.size(), n);
        end
        bad = 1'b0;
        for (int k = 0; k < n && k < iss_q.size(); k++) begin
            exp_a = (si + k * st) % DEPTH;
            if (iss_q[k] != exp_a && !bad) begin
                bad = 1'b1;
                $display("FAIL %s addr[%0d]: got %0d, required %0d", name, k, iss_q[k], exp_a);
            end
        end
        tests_run++;
        if (bad) tests_failed++;

        tests_run++;
        if (got_q.size() != n) begin
            tests_failed++;
            $display("FAIL %s word_count: got %0d transfers, required %0d", name, got_q.size(), n);
        end
        bad = 1'b0;
        for (int k = 0; k < n && k < got_q.size(); k++) begin
            exp_a = (si + k * st) % DEPTH;
            if (got_q[k] !== ram[exp_a] && !bad) begin
                bad = 1'b1;
                $display("FAIL %s data[%0d]: got %0h, required %0h (RAM[%0d])",
                         name, k, got_q[k], ram[exp_a], exp_a);
            end
        end
        tests_run++;
        if (bad) tests_failed++;

        tests_run++;
        if (o_count !== (SIZE_ADDR+1)'(n)) begin
            tests_failed++;
            $display("FAIL %s o_count: got %0d, required %0d", name, o_count, n);
        end
        tests_run++;
        if (done_cnt != 1 || done_cyc != last_xfer_cyc + 1) begin
            tests_failed++;
            $display("FAIL %s done_pulse: %0d pulses at cycle %0d, required 1 at cycle %0d",
                     name, done_cnt, done_cyc, last_xfer_cyc + 1);
        end
        tests_run++;
        if (o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s busy_after: got %0b, required 0 (held start must not retrigger)",
                     name, o_busy);
        end
        if (mode == 0) begin
            tests_run++;
            if (first_valid_cyc != start_cyc + 3) begin
                tests_failed++;
                $display("FAIL %s first_valid_latency: got %0d, required %0d",
                         name, first_valid_cyc - start_cyc, 3);
            end
        end
        i_start = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        i_rst            = 1'b1;
        i_start          = 1'b0;
        i_abort          = 1'b0;
        bus.i_data_ready = 1'b0;
        set_burst(0, 0, 1);
        tick();
        tick();
        mon_en = 1'b1;
        @(negedge i_clk);
        tests_run++;
        if ({o_busy, o_done, bus.o_data_valid, bus.o_rd_en_ram} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_flags: busy/done/valid/rd_en=%b, required 0000",
                     {o_busy, o_done, bus.o_data_valid, bus.o_rd_en_ram});
        end
        tests_run++;
        if (bus.o_addr_ram !== '0 || o_count !== '0 || bus.o_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_values: addr=%0d count=%0d data=%0h, required 0/0/0",
                     bus.o_addr_ram, o_count, bus.o_data);
        end
        tick();
        i_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_burst();
        clear_mon();
        set_burst(0, 30, 1);
        bus.i_data_ready = 1'b1;
        i_start          = 1'b1;
        for (int i = 0; i < 6; i++) tick();
        i_rst   = 1'b1;
        i_start = 1'b0;
        tick();
        @(negedge i_clk);
        tests_run++;
        if ({o_busy, bus.o_data_valid, bus.o_rd_en_ram} !== 3'b000 || o_count !== '0) begin
            tests_failed++;
            $display("FAIL reset_mid: busy/valid/rd_en=%b count=%0d, required 000 and 0",
                     {o_busy, bus.o_data_valid, bus.o_rd_en_ram}, o_count);
        end
        i_rst = 1'b0;
        for (int i = 0; i < 5; i++) tick();
        tests_run++;
        if (done_cnt != 0 || o_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_mid_quiet: done pulses=%0d busy=%0b, required 0 and 0",
                     done_cnt, o_busy);
        end
    endtask

    task automatic test_abort();
        int budget;
        clear_mon();
        set_burst(0, 20, 1);
        bus.i_data_ready = 1'b1;
        i_start          = 1'b1;
        budget           = 0;
        while (got_q.size() < 3 && budget < 50) begin
            tick();
            budget++;
        end
        bus.i_data_ready = 1'b0;
        i_abort          = 1'b1;
        tick();
        i_abort = 1'b0;
        @(negedge i_clk);
        tests_run++;
        if (bus.o_data_valid !== 1'b0 || o_busy !== 1'b0 || bus.o_rd_en_ram !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_stop: valid=%0b busy=%0b rd_en=%0b, required 0/0/0",
                     bus.o_data_valid, o_busy, bus.o_rd_en_ram);
        end
        tests_run++;
        if (o_count !== (SIZE_ADDR+1)'(3)) begin
            tests_failed++;
            $display("FAIL abort_count: got %0d, required 3", o_count);
        end
        bus.i_data_ready = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        tests_run++;
        if (done_cnt != 0 || got_q.size() != 3) begin
            tests_failed++;
            $display("FAIL abort_quiet: done pulses=%0d transfers=%0d, required 0 and 3",
                     done_cnt, got_q.size());
        end
        i_start = 1'b0;
        tick();
        run_burst(5, 12, 1, 0, 1'b0, "after_abort");
    endtask

    task automatic test_start_abort_idle();
        clear_mon();
        set_burst(3, 9, 1);
        i_start = 1'b1;
        i_abort = 1'b1;
        tick();
        i_abort = 1'b0;
        tick();
        tick();
        @(negedge i_clk);
        tests_run++;
        if (o_busy !== 1'b0 || iss_q.size() != 0) begin
            tests_failed++;
            $display("FAIL start_abort_idle: busy=%0b reads=%0d, required 0 and 0",
                     o_busy, iss_q.size());
        end
        i_start = 1'b0;
        tick();
    endtask

    task automatic test_back_to_back();
        run_burst(10, 40, 1, 2, 1'b1, "poke_busy");
        run_burst(50, 55, 1, 0, 1'b0, "b2b_a");
        run_burst(56, 3, 1, 0, 1'b0, "b2b_b");
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++) begin
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)), 1,
                      int'($urandom_range(0, 2)), 1'b0, "random");
        end
    endtask

`ifdef SS_READ_BURST_STRIDE_EN
    task automatic test_stride();
        run_burst(1, 10, 4, 0, 1'b0, "stride4");
        run_burst(1, 10, 0, 0, 1'b0, "stride0");
        run_burst(60, 6, 7, 1, 1'b0, "stride7_wrap");
        for (int i = 0; i < 4; i++) begin
            run_burst(int'($urandom_range(0, DEPTH - 1)), int'($urandom_range(0, DEPTH - 1)),
                      int'($urandom_range(0, 7)), int'($urandom_range(0, 2)), 1'b0,
                      "stride_random");
        end
    endtask
`endif

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) ram[i] = SIZE_DATA'($urandom);
        test_reset();
        run_burst(2, 5, 1, 0, 1'b0, "basic");
        run_burst(62, 1, 1, 0, 1'b0, "wrap");
        run_burst(9, 9, 1, 0, 1'b0, "single");
        run_burst(0, 63, 1, 1, 1'b0, "full_toggle");
        test_abort();
        test_start_abort_idle();
        test_reset_mid_burst();
        test_back_to_back();
        test_random();
`ifdef SS_READ_BURST_STRIDE_EN
        test_stride();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
